// File: rtl/shift_arbiter.sv
// Two-requester arbiter for one shared external shifter; one op in flight, result 2 cycles after accept, held until rsp_ready.
// Define SHIFT_ARB_STATS_EN to add saturating per-requester grant counters gnt_cnt0/gnt_cnt1.
module shift_arbiter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4,
    parameter int FAIR  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_data,
    input  logic [AMT_W-1:0] r0_amt,
    input  logic [1:0]       r0_mode,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_data,
    input  logic [AMT_W-1:0] r1_amt,
    input  logic [1:0]       r1_mode,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [WIDTH-1:0] shf_in,
    output logic [AMT_W-1:0] shf_val,
    output logic [1:0]       shf_mode,
    input  logic [WIDTH-1:0] shf_out,
    output logic             busy
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [15:0]      gnt_cnt0,
    output logic [15:0]      gnt_cnt1
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state;
    logic   rr_ptr;
    logic   owner;
    logic   gnt0;
    logic   gnt1;
    logic   rsp_done;

    // Grant only in IDLE; on contention the round-robin pointer (or r0) wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE) begin
            if (r0_valid && r1_valid) begin
                if (FAIR != 0 && rr_ptr) gnt1 = 1'b1;
                else                     gnt0 = 1'b1;
            end else begin
                gnt0 = r0_valid;
                gnt1 = r1_valid;
            end
        end
    end

    assign r0_ready = gnt0;
    assign r1_ready = gnt1;
    assign busy     = (state != IDLE);
    assign rsp_done = owner ? rsp_ready[1] : rsp_ready[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            shf_in    <= '0;
            shf_val   <= '0;
            shf_mode  <= 2'b00;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rsp_valid <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        owner    <= gnt1;
                        shf_in   <= gnt1 ? r1_data : r0_data;
                        shf_val  <= gnt1 ? r1_amt  : r0_amt;
                        shf_mode <= gnt1 ? r1_mode : r0_mode;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    // Reserved mode never trusts the shifter output.
                    if (shf_mode == 2'b11) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        rsp_data <= shf_out;
                        rsp_err  <= 1'b0;
                    end
                    rsp_valid <= owner ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        rsp_valid <= 2'b00;
                        if (FAIR != 0) rr_ptr <= ~owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SHIFT_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt0 <= 16'h0000;
            gnt_cnt1 <= 16'h0000;
        end else begin
            if (gnt0 && gnt_cnt0 != 16'hFFFF) gnt_cnt0 <= gnt_cnt0 + 16'd1;
            if (gnt1 && gnt_cnt1 != 16'hFFFF) gnt_cnt1 <= gnt_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed ops, reset mid-op, fairness for both FAIR settings, randomized run against a transaction model.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r0_ready, r1_valid, r1_ready;
    logic [15:0] r0_data, r1_data;
    logic [3:0]  r0_amt, r1_amt;
    logic [1:0]  r0_mode, r1_mode;
    logic [1:0]  rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [15:0] shf_in, shf_out;
    logic [3:0]  shf_val;
    logic [1:0]  shf_mode;
    logic        busy;

    logic        fp_r0_valid, fp_r0_ready, fp_r1_valid, fp_r1_ready;
    logic [1:0]  fp_rsp_valid, fp_rsp_ready;
    logic [15:0] fp_rsp_data;
    logic        fp_rsp_err;
    logic [15:0] fp_shf_in, fp_shf_out;
    logic [3:0]  fp_shf_val;
    logic [1:0]  fp_shf_mode;
    logic        fp_busy;
`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1, fp_gnt_cnt0, fp_gnt_cnt1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Stand-in for the external shifter, bit by bit; reserved mode returns junk on purpose.
    function automatic logic [15:0] shifter(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m);
        logic [15:0] o;
        int          s;
        o = ~d;
        if (m != 2'b11) begin
            for (int i = 0; i < 16; i++) begin
                s = i + int'(a);
                case (m)
                    2'b00:   o[i] = (i >= int'(a)) ? d[i - int'(a)] : 1'b0;
                    2'b01:   o[i] = (s <= 15) ? d[s] : d[15];
                    default: o[i] = d[s % 16];
                endcase
            end
        end
        return o;
    endfunction

    // Expected result straight from the mode definitions.
    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m);
        logic signed [15:0] sd;
        logic [31:0]        dd;
        sd = d;
        dd = {d, d} >> a;
        case (m)
            2'b00:   return d << a;
            2'b01:   return sd >>> a;
            2'b10:   return dd[15:0];
            default: return 16'h0000;
        endcase
    endfunction

    always_comb shf_out    = shifter(shf_in, shf_val, shf_mode);
    always_comb fp_shf_out = shifter(fp_shf_in, fp_shf_val, fp_shf_mode);

    shift_arbiter #(.WIDTH(16), .AMT_W(4), .FAIR(1)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_data(r0_data), .r0_amt(r0_amt), .r0_mode(r0_mode),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_data(r1_data), .r1_amt(r1_amt), .r1_mode(r1_mode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .shf_in(shf_in), .shf_val(shf_val), .shf_mode(shf_mode), .shf_out(shf_out),
        .busy(busy)
`ifdef SHIFT_ARB_STATS_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
    );

    shift_arbiter #(.WIDTH(16), .AMT_W(4), .FAIR(0)) dut_fp (
        .clk(clk), .rst(rst),
        .r0_valid(fp_r0_valid), .r0_ready(fp_r0_ready), .r0_data(r0_data), .r0_amt(r0_amt), .r0_mode(r0_mode),
        .r1_valid(fp_r1_valid), .r1_ready(fp_r1_ready), .r1_data(r1_data), .r1_amt(r1_amt), .r1_mode(r1_mode),
        .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready), .rsp_data(fp_rsp_data), .rsp_err(fp_rsp_err),
        .shf_in(fp_shf_in), .shf_val(fp_shf_val), .shf_mode(fp_shf_mode), .shf_out(fp_shf_out),
        .busy(fp_busy)
`ifdef SHIFT_ARB_STATS_EN
        , .gnt_cnt0(fp_gnt_cnt0), .gnt_cnt1(fp_gnt_cnt1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One op from an idle arbiter; result held for `hold` extra cycles before rsp_ready.
    task automatic run_op(input int req, input logic [15:0] d, input logic [3:0] a, input logic [1:0] m,
                          input int hold, input logic [15:0] exp_d, input logic exp_e, input string tag);
        logic [1:0] oh;
        oh = (req == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        if (req == 0) begin
            r0_valid = 1'b1; r0_data = d; r0_amt = a; r0_mode = m;
        end else begin
            r1_valid = 1'b1; r1_data = d; r1_amt = a; r1_mode = m;
        end
        #1;
        check({tag, ".rdy"}, {30'd0, r1_ready, r0_ready}, {30'd0, oh});
        @(negedge clk);
        // EXEC: fresh requests with scrambled operands must be neither accepted nor captured.
        r0_valid = 1'b1; r1_valid = 1'b1;
        r0_data = ~d; r1_data = ~d; r0_amt = ~a; r1_amt = ~a;
        #1;
        check({tag, ".exec_busy"}, {31'd0, busy}, 32'd1);
        check({tag, ".exec_rv"}, {30'd0, rsp_valid}, 32'd0);
        check({tag, ".exec_rdy"}, {30'd0, r1_ready, r0_ready}, 32'd0);
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk);
            check({tag, ".rv"}, {30'd0, rsp_valid}, {30'd0, oh});
            check({tag, ".data"}, {16'd0, rsp_data}, {16'd0, exp_d});
            check({tag, ".err"}, {31'd0, rsp_err}, {31'd0, exp_e});
            check({tag, ".resp_rdy"}, {30'd0, r1_ready, r0_ready}, 32'd0);
            if (i == hold) begin
                rsp_ready = oh; r0_valid = 1'b0; r1_valid = 1'b0;
            end else begin
                rsp_ready = ~oh;
            end
        end
        @(negedge clk);
        rsp_ready = 2'b00;
        check({tag, ".done_busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".done_rv"}, {30'd0, rsp_valid}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [15:0] tab_exp [6];
    logic [1:0]  tab_mode[6];
    logic [3:0]  tab_amt [6];
    int          grants[$];
    int          fp_g0, fp_g1;
    logic        pend, own, prio;
    int          due;
    logic [15:0] pdat;
    logic        perr;
    logic [1:0]  exp_rdy, exp_rv;
    logic [31:0] rnd;

    initial begin
        rst = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 2'b00;
        r0_data = '0; r1_data = '0; r0_amt = '0; r1_amt = '0; r0_mode = '0; r1_mode = '0;
        fp_r0_valid = 1'b0; fp_r1_valid = 1'b0; fp_rsp_ready = 2'b00;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.rv", {30'd0, rsp_valid}, 32'd0);
        check("rst.rdy", {30'd0, r1_ready, r0_ready}, 32'd0);
        check("rst.data", {16'd0, rsp_data}, 32'd0);
        check("rst.err", {31'd0, rsp_err}, 32'd0);
        check("rst.shf", {10'd0, shf_in, shf_val, shf_mode}, 32'd0);
        rst = 1'b0;

        // Documented examples
        run_op(0, 16'h8001, 4'd1, 2'b00, 0, 16'h0002, 1'b0, "sll");
        run_op(1, 16'h8000, 4'd4, 2'b01, 5, 16'hF800, 1'b0, "sra_hold");
        run_op(1, 16'h0001, 4'd1, 2'b10, 0, 16'h8000, 1'b0, "ror");
        run_op(0, 16'hFFFF, 4'd3, 2'b11, 1, 16'h0000, 1'b1, "reserved");

        // Amount boundaries 0 and 15 for every mode, operand 16'hB3C5
        tab_mode = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
        tab_amt  = '{4'd0, 4'd0, 4'd0, 4'd15, 4'd15, 4'd15};
        tab_exp  = '{16'hB3C5, 16'hB3C5, 16'hB3C5, 16'h8000, 16'hFFFF, 16'h678B};
        for (int k = 0; k < 6; k++)
            run_op(k % 2, 16'hB3C5, tab_amt[k], tab_mode[k], 0, tab_exp[k], 1'b0, "amt_edge");

        // Reset asserted during EXEC discards the op
        @(negedge clk);
        r0_valid = 1'b1; r0_data = 16'h1234; r0_amt = 4'd2; r0_mode = 2'b00;
        @(negedge clk);
        r0_valid = 1'b0;
        check("mid.busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid.busy", {31'd0, busy}, 32'd0);
        check("mid.rv", {30'd0, rsp_valid}, 32'd0);
        check("mid.shf_in", {16'd0, shf_in}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid.no_rsp", {30'd0, rsp_valid}, 32'd0);
            check("mid.idle", {31'd0, busy}, 32'd0);
        end

        // Round-robin with both requesters always valid; pointer starts at 0 after reset
        r0_valid = 1'b1; r1_valid = 1'b1; rsp_ready = 2'b11;
        fp_r0_valid = 1'b1; fp_r1_valid = 1'b1; fp_rsp_ready = 2'b11;
        fp_g0 = 0; fp_g1 = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            check("rr.not_both", {31'd0, r0_ready & r1_ready}, 32'd0);
            if (r0_ready) grants.push_back(0);
            if (r1_ready) grants.push_back(1);
            if (fp_r0_ready) fp_g0++;
            if (fp_r1_ready) fp_g1++;
            @(negedge clk);
        end
        r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 2'b00;
        fp_r0_valid = 1'b0; fp_r1_valid = 1'b0; fp_rsp_ready = 2'b00;
        check("rr.count", grants.size(), 32'd4);
        for (int i = 0; i < grants.size(); i++)
            check("rr.order", grants[i], i % 2);
        check("fixed.r0_grants", fp_g0, 32'd4);
        check("fixed.r1_starved", fp_g1, 32'd0);

`ifdef SHIFT_ARB_STATS_EN
        run_op(0, 16'h00F0, 4'd4, 2'b00, 0, 16'h0F00, 1'b0, "stats_op");
        check("stats.cnt0", {16'd0, gnt_cnt0}, 32'd3);
        check("stats.cnt1", {16'd0, gnt_cnt1}, 32'd2);
`endif

        // Randomized traffic against a transaction-level model: at most one op
        // outstanding, result visible two cycles after accept, contention goes to
        // the requester that was not served last.
        do_reset();
        pend = 1'b0; own = 1'b0; prio = 1'b0; due = 0; pdat = '0; perr = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            rnd = $urandom;
            r0_valid = rnd[0]; r1_valid = rnd[1]; rsp_ready = rnd[3:2];
            r0_amt = rnd[7:4]; r1_amt = rnd[11:8]; r0_mode = rnd[13:12]; r1_mode = rnd[15:14];
            r0_data = rnd[31:16];
            rnd = $urandom;
            r1_data = rnd[15:0];
            #1;
            exp_rdy = 2'b00;
            if (!pend) begin
                if (r0_valid && r1_valid) exp_rdy = prio ? 2'b10 : 2'b01;
                else                      exp_rdy = {r1_valid, r0_valid};
            end
            exp_rv = (pend && cyc >= due) ? (own ? 2'b10 : 2'b01) : 2'b00;
            check("rnd.rdy", {30'd0, r1_ready, r0_ready}, {30'd0, exp_rdy});
            check("rnd.rv", {30'd0, rsp_valid}, {30'd0, exp_rv});
            check("rnd.busy", {31'd0, busy}, {31'd0, pend});
            if (exp_rv != 2'b00) begin
                check("rnd.data", {16'd0, rsp_data}, {16'd0, pdat});
                check("rnd.err", {31'd0, rsp_err}, {31'd0, perr});
            end
            if (exp_rv != 2'b00 && rsp_ready[own]) begin
                pend = 1'b0;
                prio = ~own;
            end else if (exp_rdy != 2'b00) begin
                pend = 1'b1;
                own  = exp_rdy[1];
                due  = cyc + 2;
                perr = own ? (r1_mode == 2'b11) : (r0_mode == 2'b11);
                pdat = own ? ref_shift(r1_data, r1_amt, r1_mode) : ref_shift(r0_data, r0_amt, r0_mode);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
